// File: rtl/vga_bg_render.sv
// Background renderer for a VGA pixel stream: draws black, a coloured border,
// a grid or a checkerboard behind the timing signals, with a fixed 2-cycle latency.
module vga_bg_render #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          V_ACTIVE    = 768,
  parameter int          CNT_W       = 16,
  parameter int          BORDER_W    = 1,
  parameter int          CELL_LOG2   = 5,
  parameter int          BLINK_LOG2  = 4,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter logic [11:0] GRID_COLOR  = 12'h444,
  parameter logic [11:0] CHECK_COLOR = 12'h222
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [1:0]       mode_in,
  input  logic             blink_en,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  output logic [7:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] BW       = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] H_RIGHT  = CNT_W'(H_ACTIVE - BORDER_W);
  localparam logic [CNT_W-1:0] V_BOTTOM = CNT_W'(V_ACTIVE - BORDER_W);

  logic             vsync_prev;
  logic             armed;
  logic             frame_start;
  logic [1:0]       mode_q;
  logic             blink_q;

  logic [CNT_W-1:0] s1_hcount;
  logic [CNT_W-1:0] s1_vcount;
  logic             s1_hsync;
  logic             s1_vsync;
  logic             s1_hblnk;
  logic             s1_vblnk;
  logic [11:0]      s1_rgb;

  logic [11:0]      pixel_rgb;
  logic [11:0]      border_rgb;
  logic             is_border;
  logic             blink_off;
  logic             visible;

  // armed keeps a vsync that is already high at reset release from counting as an edge
  assign frame_start = vsync_in && !vsync_prev && armed;
  assign blink_off   = blink_q && frame_cnt[BLINK_LOG2];
  assign visible     = !(hblnk_in || vblnk_in) && (hcount_in < H_MAX) && (vcount_in < V_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      armed      <= 1'b0;
      mode_q     <= 2'd0;
      blink_q    <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      vsync_prev <= vsync_in;
      armed      <= 1'b1;
      if (frame_start) begin
        mode_q    <= mode_in;
        blink_q   <= blink_en;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    is_border  = 1'b1;
    border_rgb = 12'h000;
    if (vcount_in < BW)             border_rgb = 12'hff0;
    else if (vcount_in >= V_BOTTOM) border_rgb = 12'hf00;
    else if (hcount_in < BW)        border_rgb = 12'h0f0;
    else if (hcount_in >= H_RIGHT)  border_rgb = 12'h00f;
    else                            is_border  = 1'b0;
  end

  always_comb begin
    pixel_rgb = 12'h000;
    if (visible && mode_q != 2'd0) begin
      if (is_border) begin
        pixel_rgb = blink_off ? BG_COLOR : border_rgb;
      end else begin
        case (mode_q)
          2'd2: pixel_rgb = (hcount_in[CELL_LOG2-1:0] == '0 || vcount_in[CELL_LOG2-1:0] == '0)
                            ? GRID_COLOR : BG_COLOR;
          2'd3: pixel_rgb = (hcount_in[CELL_LOG2] ^ vcount_in[CELL_LOG2])
                            ? CHECK_COLOR : BG_COLOR;
          default: pixel_rgb = BG_COLOR;
        endcase
      end
    end
  end

  // Two register stages: colour is resolved into stage 1, stage 2 drives the ports
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= 12'h000;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      s1_hcount  <= hcount_in;
      s1_vcount  <= vcount_in;
      s1_hsync   <= hsync_in;
      s1_vsync   <= vsync_in;
      s1_hblnk   <= hblnk_in;
      s1_vblnk   <= vblnk_in;
      s1_rgb     <= pixel_rgb;
      hcount_out <= s1_hcount;
      vcount_out <= s1_vcount;
      hsync_out  <= s1_hsync;
      vsync_out  <= s1_vsync;
      hblnk_out  <= s1_hblnk;
      vblnk_out  <= s1_vblnk;
      rgb_out    <= s1_rgb;
    end
  end

endmodule

// File: tb/tb_vga_bg_render.sv
// Directed bench for vga_bg_render: table of pixels per mode plus sequences for
// latency, mid-frame mode change, blink, frame counter wrap and reset behaviour.
module tb_vga_bg_render;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [1:0]  mode_in;
  logic        blink_en;
  logic [15:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] h;
    logic [15:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[$];

  vga_bg_render dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .mode_in(mode_in), .blink_en(blink_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] h, input logic [15:0] v,
                                input logic hb, input logic vb);
    @(negedge clk);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = h[0];
    vsync_in  = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [15:0] h, input logic [15:0] v,
                              input logic hb, input logic vb, input logic [11:0] rgb);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({name, "_rgb"}, 64'(rgb_out), 64'(rgb));
    check({name, "_timing"},
          64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          64'({h, v, h[0], 1'b0, hb, vb}));
  endtask

  task automatic pixel(input string name, input logic [15:0] h, input logic [15:0] v,
                       input logic [11:0] rgb);
    apply_stimulus(h, v, 1'b0, 1'b0);
    check_output(name, h, v, 1'b0, 1'b0, rgb);
  endtask

  task automatic frame_start(input logic [1:0] m, input logic b);
    @(negedge clk);
    vsync_in = 1'b0;
    vblnk_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b1;
    mode_in  = m;
    blink_en = b;
    @(negedge clk);
    vsync_in = 1'b0;
    exp_fc   = (exp_fc + 1) % 256;
  endtask

  initial begin
    logic [1:0] cur_mode;
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    mode_in = 2'd0; blink_en = 1'b0;

    vecs.push_back('{2'd1, 16'd0,    16'd0,   1'b0, 1'b0, 12'hff0});
    vecs.push_back('{2'd1, 16'd5,    16'd767, 1'b0, 1'b0, 12'hf00});
    vecs.push_back('{2'd1, 16'd0,    16'd5,   1'b0, 1'b0, 12'h0f0});
    vecs.push_back('{2'd1, 16'd1023, 16'd5,   1'b0, 1'b0, 12'h00f});
    vecs.push_back('{2'd1, 16'd5,    16'd5,   1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd1, 16'd0,    16'd767, 1'b0, 1'b0, 12'hf00});
    vecs.push_back('{2'd1, 16'd1023, 16'd0,   1'b0, 1'b0, 12'hff0});
    vecs.push_back('{2'd1, 16'd1024, 16'd5,   1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd1, 16'd5,    16'd768, 1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd1, 16'd0,    16'd0,   1'b1, 1'b0, 12'h000});
    vecs.push_back('{2'd1, 16'd5,    16'd767, 1'b0, 1'b1, 12'h000});
    vecs.push_back('{2'd2, 16'd32,   16'd40,  1'b0, 1'b0, 12'h444});
    vecs.push_back('{2'd2, 16'd33,   16'd40,  1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd2, 16'd33,   16'd64,  1'b0, 1'b0, 12'h444});
    vecs.push_back('{2'd2, 16'd0,    16'd40,  1'b0, 1'b0, 12'h0f0});
    vecs.push_back('{2'd3, 16'd32,   16'd5,   1'b0, 1'b0, 12'h222});
    vecs.push_back('{2'd3, 16'd32,   16'd32,  1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd3, 16'd5,    16'd32,  1'b0, 1'b0, 12'h222});
    vecs.push_back('{2'd3, 16'd64,   16'd5,   1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd3, 16'd1023, 16'd767, 1'b0, 1'b0, 12'hf00});
    vecs.push_back('{2'd0, 16'd0,    16'd0,   1'b0, 1'b0, 12'h000});
    vecs.push_back('{2'd0, 16'd5,    16'd5,   1'b0, 1'b0, 12'h000});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", 64'(rgb_out), 64'h0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'h0);
    check("reset_counts", 64'({hcount_out, vcount_out}), 64'h0);
    rst = 1'b0;

    // Table pass: a new frame start latches each table mode
    frame_start(2'd1, 1'b0);
    check("first_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    cur_mode = 2'd1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].mode != cur_mode) begin
        frame_start(vecs[i].mode, 1'b0);
        cur_mode = vecs[i].mode;
      end
      apply_stimulus(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb);
      check_output($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb,
                   vecs[i].rgb);
    end

    // Exact two-cycle latency
    frame_start(2'd1, 1'b0);
    pixel("lat_pre", 16'd5, 16'd5, 12'h000);
    apply_stimulus(16'd0, 16'd5, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("lat_1cycle", 64'(rgb_out), 64'h000);
    @(posedge clk);
    @(negedge clk);
    check("lat_2cycle", 64'(rgb_out), 64'h0f0);

    // Mid-frame mode change is ignored until the next vsync edge
    @(negedge clk);
    mode_in = 2'd2;
    pixel("midframe_hold", 16'd32, 16'd40, 12'h000);
    frame_start(2'd2, 1'b0);
    pixel("midframe_grid", 16'd32, 16'd40, 12'h444);

    // Blink: restart from reset so the frame count is known
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
    repeat (15) frame_start(2'd1, 1'b1);
    pixel("blink_fc15", 16'd0, 16'd0, 12'hff0);
    frame_start(2'd1, 1'b1);
    check("blink_fc16_cnt", 64'(frame_cnt), 64'(exp_fc));
    pixel("blink_fc16_top", 16'd0, 16'd0, 12'h000);
    pixel("blink_fc16_left", 16'd0, 16'd5, 12'h000);
    frame_start(2'd1, 1'b0);
    pixel("noblink_fc17", 16'd0, 16'd5, 12'h0f0);
    while (exp_fc < 31) frame_start(2'd1, 1'b1);
    pixel("blink_fc31", 16'd1023, 16'd5, 12'h000);
    frame_start(2'd1, 1'b1);
    pixel("blink_fc32", 16'd1023, 16'd5, 12'h00f);
    while (exp_fc < 255) frame_start(2'd1, 1'b0);
    check("fc_255", 64'(frame_cnt), 64'd255);
    frame_start(2'd1, 1'b0);
    check("fc_wrap", 64'(frame_cnt), 64'd0);

    // Reset mid-line with vsync held high
    frame_start(2'd1, 1'b0);
    @(negedge clk);
    hcount_in = 16'd0; vcount_in = 16'd0; hblnk_in = 0; vblnk_in = 0; vsync_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rgb", 64'(rgb_out), 64'h0);
    check("rst_mid_vsync_out", 64'({vsync_out, hcount_out}), 64'h0);
    check("rst_mid_fc", 64'(frame_cnt), 64'h0);
    rst = 1'b0;
    exp_fc = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_vsync_high_fc", 64'(frame_cnt), 64'h0);
    check("rst_mode_cleared_rgb", 64'(rgb_out), 64'h000);
    frame_start(2'd1, 1'b0);
    check("rst_fresh_edge_fc", 64'(frame_cnt), 64'(exp_fc));
    pixel("rst_after_border", 16'd0, 16'd767, 12'hf00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/vga_bg_render.md
VGA_BG_RENDER -- requirements
Module: vga_bg_render

Interface
REQ-001 Parameter H_ACTIVE, 1024, active pixels per line.
REQ-002 Parameter V_ACTIVE, 768, active lines per frame.
REQ-003 Parameter CNT_W, 16, width of hcount/vcount buses.
REQ-004 Parameter BORDER_W, 1, border thickness in pixels (1..V_ACTIVE/2).
REQ-005 Parameter CELL_LOG2, 5, log2 of grid/checker cell size in pixels.
REQ-006 Parameter BLINK_LOG2, 4, frame-counter bit selecting the border blink phase.
REQ-007 Parameter BG_COLOR, 12'h000, interior background colour.
REQ-008 Parameter GRID_COLOR, 12'h444, grid-line colour.
REQ-009 Parameter CHECK_COLOR, 12'h222, alternate checker-cell colour.
REQ-010 Port clk input 1: single clock; all state on its rising edge.
REQ-011 Port rst input 1: reset, synchronous and active-high.
REQ-012 Ports hcount_in, vcount_in input CNT_W: pixel position from timing generator.
REQ-013 Ports hsync_in, vsync_in, hblnk_in, vblnk_in input 1 each: timing strobes.
REQ-014 Port mode_in input 2: 0 black, 1 border, 2 border+grid, 3 border+checker.
REQ-015 Port blink_en input 1: requests blinking border.
REQ-016 Ports hcount_out, vcount_out output CNT_W; hsync_out, vsync_out, hblnk_out, vblnk_out output 1 each: inputs delayed to align with rgb_out.
REQ-017 Port rgb_out output 12: pixel colour, 4 bits each R,G,B.
REQ-018 Port frame_cnt output 8: free-running frame counter.

Function
REQ-019 Latency SHALL be exactly 2 clk cycles from any input sample to its rgb_out; all *_out timing/count signals SHALL be delayed identically (2-stage register pipeline, no combinational input-to-output path).
REQ-020 Frame start SHALL be detected as vsync_in=1 in the current cycle with vsync_in=0 in the previous cycle.
REQ-021 On frame start mode_q<=mode_in, blink_q<=blink_en, frame_cnt<=frame_cnt+1 (mod 256, wraps 255->0); outside frame start these SHALL hold.
REQ-022 A mode/blink value latched at frame start SHALL apply to pixels sampled from the following cycle onward; mode_in changes mid-frame SHALL have no effect.
REQ-023 Blanked pixel (hblnk_in or vblnk_in) SHALL produce 12'h000, overriding everything.
REQ-024 Unblanked pixel with hcount_in>=H_ACTIVE or vcount_in>=V_ACTIVE SHALL produce 12'h000.
REQ-025 mode_q=0: every unblanked pixel 12'h000.
REQ-026 mode_q>=1, border priority top>bottom>left>right: vcount<BORDER_W -> 12'hff0; vcount>=V_ACTIVE-BORDER_W -> 12'hf00; hcount<BORDER_W -> 12'h0f0; hcount>=H_ACTIVE-BORDER_W -> 12'h00f.
REQ-027 Border pixel SHALL be drawn BG_COLOR instead when blink_q=1 and frame_cnt[BLINK_LOG2]=1.
REQ-028 Interior, mode_q=1: BG_COLOR.
REQ-029 Interior, mode_q=2: GRID_COLOR if hcount[CELL_LOG2-1:0]==0 or vcount[CELL_LOG2-1:0]==0, else BG_COLOR.
REQ-030 Interior, mode_q=3: CHECK_COLOR if hcount[CELL_LOG2]^vcount[CELL_LOG2]==1, else BG_COLOR.
REQ-031 Comparisons SHALL be unsigned at CNT_W bits; H_ACTIVE-BORDER_W computed as constant.

Reset
REQ-032 While rst=1 at a clk edge: rgb_out, all *_out, frame_cnt, mode_q, blink_q, both pipeline stages and the vsync history bit SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL discard in-flight pixels; first valid output appears 2 cycles after the first non-reset sample.
REQ-034 A vsync_in already high when rst deasserts SHALL NOT count as frame start.

Verification
REQ-035 Reset then 1024x768 frame, mode_in=1, one frame start -> frame_cnt=1; pixel (0,0) rgb_out=12'hff0 2 cycles later; (5,767) 12'hf00; (0,5) 12'h0f0; (1023,5) 12'h00f; (5,5) 12'h000.
REQ-036 mode_q=2, CELL_LOG2=5 -> (32,40)=12'h444, (33,40)=12'h000; mode_q=3 -> (32,5)=12'h222, (32,32)=12'h000.
REQ-037 mode_in 1->2 mid-frame -> output unchanged until next vsync_in rising edge, then grid visible.
REQ-038 blink_en=1, run 32 frames -> border colours during frame_cnt 16..31 replaced by BG_COLOR; frame_cnt wraps 255->0 after 256 frames.
REQ-039 hblnk_in=1 on border pixel -> rgb_out=12'h000; all *_out equal inputs delayed exactly 2 cycles.
REQ-040 rst pulsed mid-line with vsync_in=1 -> all outputs 0 next cycle, frame_cnt stays 0 until a fresh vsync_in 0->1 edge.
